// File: rtl/conv_layer_seq.sv
// Per-layer sequencer for one CNN conv layer: filter load, IFM row buffering,
// sliding-window load, conv-engine handshake and back-pressured OFM writes.
module conv_layer_seq #(
  parameter int ADDR_W   = 10,
  parameter int IN_W     = 16,
  parameter int K        = 4,
  parameter int STRIDE   = 1,
  parameter int N_ROWS   = 10,
  parameter int N_FILT   = 4,
  parameter int FILT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] ofm_base,
  input  logic              conv_done,
  input  logic              ofm_ready,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N_FILT-1:0] filt_we,
  output logic [5:0]        filt_addr,
  output logic              buf_we,
  output logic [5:0]        buf_addr,
  output logic              win_we,
  output logic [5:0]        win_addr,
  output logic              conv_start,
  output logic              acc_clr,
  output logic              ofm_we,
  output logic [ADDR_W-1:0] ofm_addr
);

  localparam int W_OUT = (IN_W - K) / STRIDE + 1;
  localparam int T_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int F_W   = (N_FILT   > 1) ? $clog2(N_FILT)   : 1;
  localparam int C_W   = (IN_W     > 1) ? $clog2(IN_W)     : 1;
  localparam int R_W   = (N_ROWS   > 1) ? $clog2(N_ROWS)   : 1;
  localparam int WN_W  = (W_OUT    > 1) ? $clog2(W_OUT)    : 1;
  localparam int I_W   = (K        > 1) ? $clog2(K)        : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_FILT, S_LD_BUF, S_LD_WIN, S_CONV, S_WRITE, S_DONE
  } state_t;

  state_t            state;
  logic [T_W-1:0]    t;
  logic [F_W-1:0]    f;
  logic [C_W-1:0]    c;
  logic [R_W-1:0]    row;
  logic [WN_W-1:0]   win;
  logic [I_W-1:0]    i;
  logic              conv_wait;
  logic [ADDR_W-1:0] filt_base_q;
  logic [ADDR_W-1:0] ifm_base_q;
  logic [ADDR_W-1:0] ofm_base_q;

  logic              first_win;
  logic [I_W-1:0]    win_last;
  logic              last_tap;
  logic              last_filt;
  logic              last_col;
  logic              last_win;
  logic              last_row;

  assign first_win = (win == '0);
  // The first window of a row fills all K slots; later ones only shift in STRIDE new elements.
  assign win_last  = first_win ? I_W'(K - 1) : I_W'(STRIDE - 1);
  assign last_tap  = (t   == T_W'(FILT_LEN - 1));
  assign last_filt = (f   == F_W'(N_FILT - 1));
  assign last_col  = (c   == C_W'(IN_W - 1));
  assign last_win  = (win == WN_W'(W_OUT - 1));
  assign last_row  = (row == R_W'(N_ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      t           <= '0;
      f           <= '0;
      c           <= '0;
      row         <= '0;
      win         <= '0;
      i           <= '0;
      conv_wait   <= 1'b0;
      filt_base_q <= '0;
      ifm_base_q  <= '0;
      ofm_base_q  <= '0;
    end else if (abort && state != S_IDLE) begin
      state     <= S_IDLE;
      t         <= '0;
      f         <= '0;
      c         <= '0;
      row       <= '0;
      win       <= '0;
      i         <= '0;
      conv_wait <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            filt_base_q <= filt_base;
            ifm_base_q  <= ifm_base;
            ofm_base_q  <= ofm_base;
            t           <= '0;
            f           <= '0;
            c           <= '0;
            row         <= '0;
            win         <= '0;
            i           <= '0;
            conv_wait   <= 1'b0;
            state       <= S_LD_FILT;
          end
        end
        S_LD_FILT: begin
          if (last_tap) begin
            t <= '0;
            if (last_filt) begin
              f     <= '0;
              row   <= '0;
              state <= S_LD_BUF;
            end else begin
              f <= f + 1'b1;
            end
          end else begin
            t <= t + 1'b1;
          end
        end
        S_LD_BUF: begin
          if (last_col) begin
            c     <= '0;
            win   <= '0;
            i     <= '0;
            state <= S_LD_WIN;
          end else begin
            c <= c + 1'b1;
          end
        end
        S_LD_WIN: begin
          if (i == win_last) begin
            i         <= '0;
            conv_wait <= 1'b0;
            state     <= S_CONV;
          end else begin
            i <= i + 1'b1;
          end
        end
        S_CONV: begin
          // conv_done is not trusted in the same cycle as conv_start.
          if (!conv_wait) conv_wait <= 1'b1;
          else if (conv_done) state <= S_WRITE;
        end
        S_WRITE: begin
          if (ofm_ready) begin
            if (!last_win) begin
              win   <= win + 1'b1;
              state <= S_LD_WIN;
            end else if (!last_row) begin
              row   <= row + 1'b1;
              win   <= '0;
              state <= S_LD_BUF;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          row   <= '0;
          win   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready      = (state == S_IDLE);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    mem_rd     = 1'b0;
    mem_addr   = '0;
    filt_we    = '0;
    filt_addr  = '0;
    buf_we     = 1'b0;
    buf_addr   = '0;
    win_we     = 1'b0;
    win_addr   = '0;
    conv_start = 1'b0;
    acc_clr    = 1'b0;
    ofm_we     = 1'b0;
    ofm_addr   = '0;
    case (state)
      S_LD_FILT: begin
        mem_rd    = 1'b1;
        mem_addr  = filt_base_q + ADDR_W'(32'(f) * FILT_LEN + 32'(t));
        filt_we   = N_FILT'(1) << f;
        filt_addr = 6'(t);
      end
      S_LD_BUF: begin
        mem_rd   = 1'b1;
        buf_we   = 1'b1;
        mem_addr = ifm_base_q + ADDR_W'(32'(row) * IN_W + 32'(c));
        buf_addr = 6'(c);
      end
      S_LD_WIN: begin
        win_we = 1'b1;
        if (first_win) begin
          win_addr = 6'(i);
          buf_addr = 6'(i);
        end else begin
          win_addr = 6'(K - STRIDE + 32'(i));
          buf_addr = 6'(32'(win) * STRIDE + K - STRIDE + 32'(i));
        end
      end
      S_CONV: conv_start = !conv_wait;
      S_WRITE: begin
        ofm_addr = ofm_base_q + ADDR_W'(32'(row) * W_OUT + 32'(win));
        ofm_we   = ofm_ready && !abort;
        acc_clr  = ofm_ready;
      end
      default: ;
    endcase
  end

endmodule
